pingpang_packer: RTL and testbench

PINGPANG_PACKER -- requirements
Module: pingpang_packer

---
 rtl/pingpang_packer.sv | 104 ++++++++++
 tb/tb_pingpang_packer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pingpang_packer.sv
// -----------------------------------------------------------------------------
// pingpang_packer
//   Packs a stream of 32-bit words into 128-bit words using two ping-pong
//   buffers. The write side fills one buffer while the read side drains the
//   other, so with dout_ready held high the input never stalls.
//
//   Handshake rule (both sides): a transfer happens on a rising clk edge
//   where valid && ready are both high. valid never depends on ready.
//   din_ready and dout/dout_valid are combinational from registered state.
//
// Ports
//   clk        in   1    system clock, rising edge
//   rst_n      in   1    synchronous active-low reset
//   din        in   32   narrow input word
//   din_valid  in   1    din carries a word
//   din_ready  out  1    a word can be accepted this cycle
//   dout       out  128  packed wide word (buffer selected by read pointer)
//   dout_valid out  1    dout holds a complete word
//   dout_ready in   1    downstream accepts dout this cycle
//
// Configuration
//   PINGPANG_MSB_FIRST_EN  defined: first word of a group lands in bits
//                          [127:96]; undefined: first word in bits [31:0].
// -----------------------------------------------------------------------------
module pingpang_packer (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [31:0]  din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic [127:0] dout,
   output logic         dout_valid,
   input  logic         dout_ready
);

   logic [127:0] r_buf0;
   logic [127:0] r_buf1;
   logic [1:0]   r_full;
   logic         r_wr_sel;
   logic         r_rd_sel;
   logic [1:0]   r_wcnt;

   logic         w_accept;
   logic         w_drain;
   logic         w_last;
   logic [1:0]   w_lane;
   logic [1:0]   w_full_nxt;

   assign din_ready  = !r_full[r_wr_sel];
   assign dout       = r_rd_sel ? r_buf1 : r_buf0;
   assign dout_valid = r_full[r_rd_sel];

   assign w_accept = din_valid && din_ready;
   assign w_drain  = dout_valid && dout_ready;
   assign w_last   = (r_wcnt == 2'd3);

   // 32-bit lane within the 128-bit buffer that the current word fills.
`ifdef PINGPANG_MSB_FIRST_EN
   assign w_lane = ~r_wcnt;
`else
   assign w_lane = r_wcnt;
`endif

   // Fill and drain can hit the same cycle; they always target different
   // buffers (fill needs its buffer empty, drain needs its buffer full),
   // so applying both updates independently is safe.
   always_comb begin
      w_full_nxt = r_full;
      if (w_drain) begin
         w_full_nxt[r_rd_sel] = 1'b0;
      end
      if (w_accept && w_last) begin
         w_full_nxt[r_wr_sel] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_buf0   <= '0;
         r_buf1   <= '0;
         r_full   <= 2'b00;
         r_wr_sel <= 1'b0;
         r_rd_sel <= 1'b0;
         r_wcnt   <= 2'd0;
      end else begin
         if (w_accept) begin
            if (!r_wr_sel) begin
               r_buf0[{w_lane, 5'd0} +: 32] <= din;
            end else begin
               r_buf1[{w_lane, 5'd0} +: 32] <= din;
            end
            r_wcnt <= r_wcnt + 2'd1;
            if (w_last) begin
               r_wr_sel <= ~r_wr_sel;
            end
         end
         if (w_drain) begin
            r_rd_sel <= ~r_rd_sel;
         end
         r_full <= w_full_nxt;
      end
   end

endmodule

// File: tb/tb_pingpang_packer.sv
// -----------------------------------------------------------------------------
// tb_pingpang_packer
//   Self-checking bench for pingpang_packer. A reference model holds the
//   partial group as a list of words and completed groups as a FIFO of at
//   most two packed words; din_ready, dout_valid and dout are predicted from
//   those lists every cycle. Honours PINGPANG_MSB_FIRST_EN for packing order.
// -----------------------------------------------------------------------------
module tb_pingpang_packer;

   logic         clk;
   logic         rst_n;
   logic [31:0]  din;
   logic         din_valid;
   logic         din_ready;
   logic [127:0] dout;
   logic         dout_valid;
   logic         dout_ready;

   pingpang_packer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- reference model ----------------
   logic [31:0]  part_q[$];  // words of the group being collected
   logic [127:0] out_q[$];   // completed groups not yet taken downstream
   logic [127:0] log_q[$];   // groups taken downstream (for directed checks)
   logic         last_acc;

   function automatic logic [127:0] pack4(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3);
`ifdef PINGPANG_MSB_FIRST_EN
      return {w0, w1, w2, w3};
`else
      return {w3, w2, w1, w0};
`endif
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_clear();
      part_q.delete();
      out_q.delete();
      log_q.delete();
   endtask

   // One clock cycle: drive inputs, check outputs against the model,
   // advance through the rising edge and update the model.
   task automatic cycle(input logic v, input logic [31:0] d, input logic r);
      logic m_ready;
      logic m_valid;
      din_valid  = v;
      din        = d;
      dout_ready = r;
      #1;
      m_ready = (out_q.size() < 2);
      m_valid = (out_q.size() > 0);
      chk("din_ready", {127'b0, din_ready}, {127'b0, m_ready});
      chk("dout_valid", {127'b0, dout_valid}, {127'b0, m_valid});
      if (m_valid) chk("dout", dout, out_q[0]);
      @(posedge clk);
      #1;
      last_acc = v && m_ready;
      if (r && m_valid) log_q.push_back(out_q.pop_front());
      if (last_acc) begin
         part_q.push_back(d);
         if (part_q.size() == 4) begin
            out_q.push_back(pack4(part_q[0], part_q[1], part_q[2], part_q[3]));
            part_q.delete();
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      din_valid = 1'b0;
      din = 32'h0;
      dout_ready = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
      chk("rst_dout", dout, 128'h0);
      chk("rst_dout_valid", {127'b0, dout_valid}, 128'h0);
      chk("rst_din_ready", {127'b0, din_ready}, 128'h1);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [127:0] exp_w;
      int idx;
      int n_valid_seen;
      logic ph;

      rst_n = 1'b0;
      din_valid = 1'b0;
      din = 32'h0;
      dout_ready = 1'b0;
      last_acc = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Basic group of four, output visible for exactly one cycle.
      cycle(1'b1, 32'h11111111, 1'b1);
      cycle(1'b1, 32'h22222222, 1'b1);
      cycle(1'b1, 32'h33333333, 1'b1);
      cycle(1'b1, 32'h44444444, 1'b1);
`ifdef PINGPANG_MSB_FIRST_EN
      exp_w = 128'h11111111_22222222_33333333_44444444;
`else
      exp_w = 128'h44444444_33333333_22222222_11111111;
`endif
      din_valid = 1'b0;
      dout_ready = 1'b1;
      #1;
      chk("basic_valid", {127'b0, dout_valid}, 128'h1);
      chk("basic_dout", dout, exp_w);
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      chk("basic_log_n", 128'(log_q.size()), 128'd1);
      chk("basic_log", log_q[0], exp_w);

      // Back-pressure: both buffers fill, word 9 waits on din.
      do_reset();
      idx = 1;
      for (int c = 0; c < 40; c++) begin
         if (idx <= 12) begin
            cycle(1'b1, 32'(idx), (c >= 12));
            if (last_acc) idx++;
         end else begin
            cycle(1'b0, 32'h0, 1'b1);
         end
         if (c == 10) chk("bp_stalled_at_9", 128'(idx), 128'd9);
      end
      chk("bp_all_sent", 128'(idx), 128'd13);
      chk("bp_log_n", 128'(log_q.size()), 128'd3);
      chk("bp_out0", log_q[0], pack4(32'd1, 32'd2, 32'd3, 32'd4));
      chk("bp_out1", log_q[1], pack4(32'd5, 32'd6, 32'd7, 32'd8));
      chk("bp_out2", log_q[2], pack4(32'd9, 32'd10, 32'd11, 32'd12));

      // Sustained streaming: 64 words, ready never drops.
      do_reset();
      n_valid_seen = 0;
      for (int c = 0; c < 64; c++) begin
         cycle(1'b1, 32'hA000_0000 + 32'(c), 1'b1);
         if (!last_acc) chk("stream_accept", 128'h0, 128'h1);
      end
      for (int c = 0; c < 4; c++) cycle(1'b0, 32'h0, 1'b1);
      chk("stream_log_n", 128'(log_q.size()), 128'd16);
      for (int g = 0; g < 16; g++) begin
         chk("stream_word", log_q[g],
             pack4(32'hA000_0000 + 32'(4*g), 32'hA000_0000 + 32'(4*g+1),
                   32'hA000_0000 + 32'(4*g+2), 32'hA000_0000 + 32'(4*g+3)));
      end

      // Reset in the middle of a group discards the partial words.
      do_reset();
      cycle(1'b1, 32'hDEAD0001, 1'b0);
      cycle(1'b1, 32'hDEAD0002, 1'b0);
      do_reset();
      cycle(1'b1, 32'h0000000A, 1'b1);
      cycle(1'b1, 32'h0000000B, 1'b1);
      cycle(1'b1, 32'h0000000C, 1'b1);
      cycle(1'b1, 32'h0000000D, 1'b1);
      for (int c = 0; c < 4; c++) cycle(1'b0, 32'h0, 1'b1);
      chk("midrst_log_n", 128'(log_q.size()), 128'd1);
      chk("midrst_word", log_q[0], pack4(32'hA, 32'hB, 32'hC, 32'hD));

      // Random: din_valid toggles, dout_ready random, data random.
      do_reset();
      ph = 1'b1;
      for (int c = 0; c < 300; c++) begin
         cycle(ph, $urandom, 1'($urandom_range(0, 1)));
         ph = ~ph;
      end
      for (int c = 0; c < 6; c++) cycle(1'b0, 32'h0, 1'b1);
      chk("rand_drained", 128'(out_q.size()), 128'd0);
      chk("rand_some_out", 128'(log_q.size() > 10), 128'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
